// File: rtl/conv_stream_p_if.sv
// Valid/ready bundle for the conv_stream_p engine: filter port, sample
// port and result port. The engine sits on the slave side; the stream
// source and the result consumer together form the master side.
interface conv_stream_p_if #(
  parameter int T = 16
);
  logic [T-1:0] f_data;
  logic         f_valid;
  logic         f_ready;
  logic [T-1:0] x_data;
  logic         x_valid;
  logic         x_ready;
  logic [T-1:0] y_data;
  logic         y_valid;
  logic         y_ready;

  modport master (
    output f_data, f_valid, x_data, x_valid, y_ready,
    input  f_ready, x_ready, y_data, y_valid
  );

  modport slave (
    input  f_data, f_valid, x_data, x_valid, y_ready,
    output f_ready, x_ready, y_data, y_valid
  );
endinterface

// File: rtl/conv_stream_p.sv
// Streaming 1-D valid convolution engine. A filter of SIZE_F taps is
// loaded at run time, then each SIZE_X sample vector is convolved by P
// saturating MAC lanes and the N results are drained in order. After a
// vector the stored filter is reused unless a new filter is offered.
module conv_stream_p #(
  parameter int T      = 16,
  parameter int SIZE_F = 8,
  parameter int SIZE_X = 16,
  parameter int P      = 1,
  parameter int RELU   = 1
) (
  input logic            clk,
  input logic            reset,
  conv_stream_p_if.slave bus
);

  localparam int N   = SIZE_X - SIZE_F + 1;
  localparam int FAW = (SIZE_F > 1) ? $clog2(SIZE_F) : 1;
  localparam int XAW = (SIZE_X > 1) ? $clog2(SIZE_X) : 1;
  localparam int YAW = (N > 1) ? $clog2(N) : 1;
  localparam int SW  = $clog2(SIZE_F + 3);
  localparam int CW  = $clog2(SIZE_X + SIZE_F + P + 4) + 1;

  localparam logic signed [2*T-1:0] PMAX = {{(T+1){1'b0}}, {(T-1){1'b1}}};
  localparam logic signed [2*T-1:0] PMIN = {{(T+1){1'b1}}, {(T-1){1'b0}}};
  localparam logic signed [T-1:0]   TMAX = {1'b0, {(T-1){1'b1}}};
  localparam logic signed [T-1:0]   TMIN = {1'b1, {(T-1){1'b0}}};

  typedef enum logic [1:0] {LOAD_F, LOAD_X, COMPUTE, DRAIN} state_t;

  state_t r_state;
  state_t w_next;

  logic [T-1:0] r_fRam [2**FAW];
  logic [T-1:0] r_xRam [2**XAW];
  logic [T-1:0] r_yBuf [2**YAW];

  logic [FAW-1:0] r_fCnt;
  logic [XAW-1:0] r_xCnt;
  logic [YAW-1:0] r_dCnt;
  logic [SW-1:0]  r_step;
  logic [CW-1:0]  r_base;

  logic                r_rdValid;
  logic                r_prodValid;
  logic signed [T-1:0] r_fRd;
  logic signed [T-1:0] r_xRd  [P];
  logic signed [T-1:0] r_prod [P];
  logic signed [T-1:0] r_acc  [P];

  logic                  w_fFire;
  logic                  w_xFire;
  logic                  w_yFire;
  logic                  w_stepLast;
  logic                  w_groupLast;
  logic [CW-1:0]         w_laneY  [P];
  logic [CW-1:0]         w_xAddr  [P];
  logic signed [2*T-1:0] w_mul    [P];
  logic signed [T-1:0]   w_result [P];

  // Clamp a full-width product into the T-bit signed range.
  function automatic logic signed [T-1:0] satProd(input logic signed [2*T-1:0] p);
    if (p > PMAX)      satProd = TMAX;
    else if (p < PMIN) satProd = TMIN;
    else               satProd = p[T-1:0];
  endfunction

  // T-bit add that sticks at the rail when both operands share a sign
  // and the wrapped sum does not.
  function automatic logic signed [T-1:0] satAdd(input logic signed [T-1:0] a,
                                                 input logic signed [T-1:0] b);
    logic signed [T-1:0] s;
    s = a + b;
    if ((a[T-1] == b[T-1]) && (s[T-1] != a[T-1])) satAdd = a[T-1] ? TMIN : TMAX;
    else                                          satAdd = s;
  endfunction

  assign w_fFire     = bus.f_valid & bus.f_ready;
  assign w_xFire     = bus.x_valid & bus.x_ready;
  assign w_yFire     = bus.y_valid & bus.y_ready;
  assign w_stepLast  = (r_step == SW'(SIZE_F + 2));
  assign w_groupLast = ((r_base + CW'(P)) >= CW'(N));

  assign bus.f_ready = (r_state == LOAD_F);
  assign bus.x_ready = (r_state == LOAD_X);
  assign bus.y_valid = (r_state == DRAIN);
  assign bus.y_data  = (r_state == DRAIN) ? r_yBuf[r_dCnt] : '0;

  // Per-lane output index, sample read address, raw product and the
  // ReLU-filtered value that gets written to the result buffer.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      w_laneY[i]  = r_base + CW'(i);
      w_xAddr[i]  = w_laneY[i] + CW'(r_step);
      w_mul[i]    = r_fRd * r_xRd[i];
      w_result[i] = ((RELU != 0) && r_acc[i][T-1]) ? '0 : r_acc[i];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= LOAD_F;
    else        r_state <= w_next;
  end

  // Next-state logic; the last drained result chooses between reloading
  // the filter and reusing it, depending on whether a filter is offered.
  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD_F:  if (w_fFire && (r_fCnt == FAW'(SIZE_F - 1))) w_next = LOAD_X;
      LOAD_X:  if (w_xFire && (r_xCnt == XAW'(SIZE_X - 1))) w_next = COMPUTE;
      COMPUTE: if (w_stepLast && w_groupLast)               w_next = DRAIN;
      DRAIN:   if (w_yFire && (r_dCnt == YAW'(N - 1)))
                 w_next = bus.f_valid ? LOAD_F : LOAD_X;
      default: w_next = LOAD_F;
    endcase
  end

  // Load, drain and compute sequencing counters; each wraps to zero so
  // the next phase or vector starts clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fCnt <= '0;
      r_xCnt <= '0;
      r_dCnt <= '0;
      r_step <= '0;
      r_base <= '0;
    end else begin
      if (w_fFire) r_fCnt <= (r_fCnt == FAW'(SIZE_F - 1)) ? '0 : r_fCnt + FAW'(1);
      if (w_xFire) r_xCnt <= (r_xCnt == XAW'(SIZE_X - 1)) ? '0 : r_xCnt + XAW'(1);
      if (w_yFire) r_dCnt <= (r_dCnt == YAW'(N - 1)) ? '0 : r_dCnt + YAW'(1);
      if (r_state == COMPUTE) begin
        if (w_stepLast) begin
          r_step <= '0;
          r_base <= w_groupLast ? '0 : r_base + CW'(P);
        end else begin
          r_step <= r_step + SW'(1);
        end
      end
    end
  end

  // Filter, sample and result storage; results are written once the
  // pipeline has flushed, and lanes past the last output are skipped.
  always_ff @(posedge clk) begin
    if (w_fFire) r_fRam[r_fCnt] <= bus.f_data;
    if (w_xFire) r_xRam[r_xCnt] <= bus.x_data;
    if ((r_state == COMPUTE) && w_stepLast) begin
      for (int i = 0; i < P; i++) begin
        if (w_laneY[i] < CW'(N)) r_yBuf[w_laneY[i][YAW-1:0]] <= w_result[i];
      end
    end
  end

  // Read stage, product stage and accumulate stage. Taps are issued
  // for the first SIZE_F steps; the remaining three steps drain the
  // read and the two MAC stages before the group is written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdValid   <= 1'b0;
      r_prodValid <= 1'b0;
      r_fRd       <= '0;
      for (int i = 0; i < P; i++) begin
        r_xRd[i]  <= '0;
        r_prod[i] <= '0;
        r_acc[i]  <= '0;
      end
    end else begin
      r_rdValid   <= (r_state == COMPUTE) && (r_step < SW'(SIZE_F));
      r_prodValid <= r_rdValid;
      r_fRd       <= r_fRam[r_step[FAW-1:0]];
      for (int i = 0; i < P; i++) begin
        r_xRd[i]  <= (w_xAddr[i] < CW'(SIZE_X)) ? r_xRam[w_xAddr[i][XAW-1:0]] : '0;
        r_prod[i] <= satProd(w_mul[i]);
        if ((r_state == COMPUTE) && (r_step == '0)) r_acc[i] <= '0;
        else if (r_prodValid)                       r_acc[i] <= satAdd(r_acc[i], r_prod[i]);
      end
    end
  end

endmodule

// File: doc/conv_stream_p.md
Name: conv_stream_p

Overview:
- Parametrised streaming 1-D valid convolution engine. Next generation of the fixed-filter conv_T_F_X_P blocks.
- The filter is loaded at run time over its own handshake port instead of from a generated ROM.
- P parallel saturating MAC lanes, selectable ReLU, and back-to-back vectors with no reset between them.
- Sits between the x stream source and the y consumer. All three ports use valid/ready.

Parameters:
T, 16, data width of x, f and y (signed two's complement)
SIZE_F, 8, filter length (>=1)
SIZE_X, 16, input vector length (>=SIZE_F)
P, 1, parallel MAC lanes (1..SIZE_X-SIZE_F+1)
RELU, 1, 1 = clamp negative outputs to 0; 0 = pass signed result

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low; all state cleared while reset==0
f_data  in  T  filter coefficient, f[0] first
f_valid  in  1  coefficient valid
f_ready  out  1  block accepts coefficient
x_data  in  T  input sample, x[0] first
x_valid  in  1  sample valid
x_ready  out  1  block accepts sample
y_data  out  T  output sample, y[0] first
y_valid  out  1  output valid
y_ready  in  1  consumer accepts output

Behaviour:
- Transfer occurs on any port when valid && ready at a rising edge. N = SIZE_X-SIZE_F+1. Output y[k] = sum over j of f[j]*x[k+j], for k = 0..N-1.
- Reset values: f_ready=1, x_ready=0, y_valid=0, y_data=0. State = LOAD_F; all counters 0.
- LOAD_F:
  - f_ready=1, x_ready=0.
  - Each transfer writes the coefficient to filter RAM at address f_cnt; f_cnt increments.
  - After SIZE_F transfers, go to LOAD_X the next cycle with f_ready=0.
- LOAD_X:
  - x_ready=1, f_ready=0.
  - Each transfer writes x RAM at address x_cnt.
  - After SIZE_X transfers, go to COMPUTE with x_ready=0.
- COMPUTE:
  - Processes groups g = 0..ceil(N/P)-1. Lane i computes y[g*P+i].
  - Lanes with index >= N are masked and never written.
  - Each group steps j = 0..SIZE_F-1. All lanes share the f[j] read; lane i reads x[g*P+i+j].
  - The memory read latency of 1 cycle and a MAC pipeline of 2 stages are flushed before results are written to the y buffer (depth N).
- DRAIN:
  - Presents y[0..N-1] in order from the y buffer.
  - y_valid stays asserted and y_data stays stable until accepted. Holding y_valid low while y_ready is low is prohibited once an output is pending.
  - Sustains one output per cycle while y_ready=1.
  - After y[N-1] is accepted: if f_valid==1 in that cycle, go to LOAD_F (new filter); otherwise go to LOAD_X and reuse the stored filter.
- Arithmetic, per lane:
  - The product is formed at 2T bits, then saturated to T bits, to [-2^(T-1), 2^(T-1)-1].
  - The accumulator is T bits. Each add is saturated: pos+pos overflow gives 2^(T-1)-1; neg+neg overflow gives -2^(T-1).
  - The accumulator clears at the start of every group.
  - If RELU=1, negative results are written as 0.
- Latency: first y_valid asserts no later than ceil(N/P)*(SIZE_F+3)+2 cycles after the last x transfer.
- Boundaries:
  - x_valid in LOAD_F and f_valid in LOAD_X/COMPUTE are ignored: the data is not consumed and the ready signal stays 0.
  - P that does not divide N: the last group is partial, and the masked lanes' results are discarded.
  - y_ready toggling every cycle in DRAIN: no output is lost or duplicated.
  - reset dropped mid-operation (any state): returns to LOAD_F at once, y_valid=0, the filter is forgotten; the partial vector is discarded.
  - SIZE_F==SIZE_X: N=1, a single output.

Test Plan:
- Filter-load/order: T=16, SIZE_F=3, SIZE_X=5, P=2, RELU=0. f=1,2,3; x=1,2,3,4,5 -> y=14,20,26, then block returns to LOAD_X with x_ready=1.
- Filter reuse: same config; second vector x=0,0,1,0,0 with f_valid low during DRAIN -> y=3,2,1 and no f transfers occur.
- Saturation: f=32767,32767,32767; x all 2 -> all y=32767. f=-32768 x3; x all 2 -> all y=-32768.
- ReLU: RELU=1, f=-1,0,0; x=5,5,5,5,5 -> y=0,0,0. Same stimulus with RELU=0 -> y=-5,-5,-5.
- Backpressure and partial group: P=2, N=3; y_ready pattern 1,0,0,1,0,1 -> exactly 3 transfers in order 14,20,26, with y_data stable across the stalls.
- Async reset: assert reset=0 mid-COMPUTE, asynchronously between clock edges -> y_valid=0 and f_ready=1 immediately. Reload f=1,2,3 with x=1..5 -> y=14,20,26.
